// File: rtl/uart_pkt_tx.sv
`timescale 1ns/1ps
// uart_pkt_tx
// Drains a byte FIFO read port and sends framed packets on a UART line
// (8 data bits, LSB first, one stop bit). Frame: 0xA5, 1..MAX_PAYLOAD
// payload bytes, XOR checksum of the payload, 0x5A.
// Build option: define UART_PARITY_EN to add an even-parity bit between
// the data bits and the stop bit of every byte (11 bit periods per byte).
module uart_pkt_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int MAX_PAYLOAD  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_valid,
  output logic                  read_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  pkt_done,
  output logic [7:0]            pkt_len
);

  // Framing bytes and limits.
  localparam logic [DATA_WIDTH-1:0] SOF_BYTE = DATA_WIDTH'(8'hA5);
  localparam logic [DATA_WIDTH-1:0] EOF_BYTE = DATA_WIDTH'(8'h5A);
  localparam logic [7:0]            MAX_LEN  = 8'(MAX_PAYLOAD);

  // Baud counter counts down from CLKS_PER_BIT-1 to 0 once per bit.
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef UART_PARITY_EN
  // Start + 8 data + parity + stop.
  localparam int FRAME_BITS = 11;
  localparam int TAIL_W     = FRAME_BITS - 1;

  // Bits that follow the start bit, LSB shifted out first.
  function automatic logic [TAIL_W-1:0] frame_tail(input logic [DATA_WIDTH-1:0] d);
    return {1'b1, ^d, d};
  endfunction
`else
  // Start + 8 data + stop.
  localparam int FRAME_BITS = 10;
  localparam int TAIL_W     = FRAME_BITS - 1;

  // Bits that follow the start bit, LSB shifted out first.
  function automatic logic [TAIL_W-1:0] frame_tail(input logic [DATA_WIDTH-1:0] d);
    return {1'b1, d};
  endfunction
`endif

  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND_SOF,
    FETCH,
    WAIT_DATA,
    SEND_PAYLOAD,
    SEND_CSUM,
    SEND_EOF,
    DONE
  } state_t;

  state_t                state_reg;
  logic                  tx_reg;
  logic                  busy_reg;
  logic                  pkt_done_reg;
  logic [7:0]            pkt_len_reg;
  logic [DATA_WIDTH-1:0] csum_reg;
  logic [7:0]            count_reg;
  logic [BAUD_W-1:0]     baud_reg;
  logic [3:0]            bit_idx_reg;
  logic [TAIL_W-1:0]     shift_reg;

  // The read strobe depends on fifo_empty in the decision cycle itself, so
  // it is decoded directly rather than registered.
  assign read_en = (state_reg == FETCH) && !fifo_empty && (count_reg < MAX_LEN);

  assign tx       = tx_reg;
  assign busy     = busy_reg;
  assign pkt_done = pkt_done_reg;
  assign pkt_len  = pkt_len_reg;

  // Packet sequencer and bit serializer; the reset forces the line idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      pkt_done_reg <= 1'b0;
      pkt_len_reg  <= 8'd0;
      csum_reg     <= '0;
      count_reg    <= 8'd0;
      baud_reg     <= '0;
      bit_idx_reg  <= 4'd0;
      shift_reg    <= '1;
    end else begin
      pkt_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          tx_reg <= 1'b1;
          if (!fifo_empty) begin
            // Start bit of SOF goes out next cycle; checksum restarts here.
            state_reg   <= SEND_SOF;
            busy_reg    <= 1'b1;
            csum_reg    <= '0;
            count_reg   <= 8'd0;
            tx_reg      <= 1'b0;
            shift_reg   <= frame_tail(SOF_BYTE);
            bit_idx_reg <= 4'd0;
            baud_reg    <= BAUD_RELOAD;
          end
        end

        FETCH: begin
          tx_reg <= 1'b1;
          if (count_reg < MAX_LEN && !fifo_empty) begin
            // read_en is high during this cycle.
            state_reg <= WAIT_DATA;
          end else if (count_reg == 8'd0) begin
            // A packet never closes without payload; hold until a byte exists.
            state_reg <= FETCH;
          end else begin
            state_reg   <= SEND_CSUM;
            tx_reg      <= 1'b0;
            shift_reg   <= frame_tail(csum_reg);
            bit_idx_reg <= 4'd0;
            baud_reg    <= BAUD_RELOAD;
          end
        end

        WAIT_DATA: begin
          tx_reg <= 1'b1;
          if (fifo_valid) begin
            state_reg   <= SEND_PAYLOAD;
            csum_reg    <= csum_reg ^ fifo_data;
            count_reg   <= count_reg + 8'd1;
            tx_reg      <= 1'b0;
            shift_reg   <= frame_tail(fifo_data);
            bit_idx_reg <= 4'd0;
            baud_reg    <= BAUD_RELOAD;
          end
        end

        SEND_SOF, SEND_PAYLOAD, SEND_CSUM, SEND_EOF: begin
          if (baud_reg != '0) begin
            baud_reg <= baud_reg - 1'b1;
          end else if (bit_idx_reg != LAST_BIT) begin
            // Next bit of the frame.
            tx_reg      <= shift_reg[0];
            shift_reg   <= {1'b1, shift_reg[TAIL_W-1:1]};
            bit_idx_reg <= bit_idx_reg + 4'd1;
            baud_reg    <= BAUD_RELOAD;
          end else begin
            // Stop bit has just finished; decide what follows this byte.
            case (state_reg)
              SEND_SOF, SEND_PAYLOAD: begin
                state_reg <= FETCH;
                tx_reg    <= 1'b1;
              end
              SEND_CSUM: begin
                // EOF follows the checksum back to back.
                state_reg   <= SEND_EOF;
                tx_reg      <= 1'b0;
                shift_reg   <= frame_tail(EOF_BYTE);
                bit_idx_reg <= 4'd0;
                baud_reg    <= BAUD_RELOAD;
              end
              SEND_EOF: begin
                state_reg    <= DONE;
                tx_reg       <= 1'b1;
                busy_reg     <= 1'b0;
                pkt_done_reg <= 1'b1;
                pkt_len_reg  <= count_reg;
              end
              default: begin
                state_reg <= IDLE;
                tx_reg    <= 1'b1;
              end
            endcase
          end
        end

        DONE: begin
          tx_reg    <= 1'b1;
          count_reg <= 8'd0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_pkt_tx.sv
`timescale 1ns/1ps
// Bench for uart_pkt_tx: a FIFO model feeds the DUT, a line decoder turns
// tx back into bytes, and a packet-level model predicts the byte stream,
// inter-byte gaps, packet lengths and read counts.
module tb_uart_pkt_tx;

  localparam int CPB  = 4;
  localparam int MAXP = 4;
`ifdef UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  localparam int R_SOF  = 0;
  localparam int R_PAY  = 1;
  localparam int R_CSUM = 2;
  localparam int R_EOF  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_valid = 1'b0;
  logic       read_en;
  logic       tx;
  logic       busy;
  logic       pkt_done;
  logic [7:0] pkt_len;

  uart_pkt_tx #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(CPB),
    .MAX_PAYLOAD (MAXP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_valid(fifo_valid),
    .read_en   (read_en),
    .tx        (tx),
    .busy      (busy),
    .pkt_done  (pkt_done),
    .pkt_len   (pkt_len)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // FIFO model: storage written by the stimulus, popped on read_en.
  logic [7:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_pulses = 0;
  int rd_err = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  initial begin : fifo_model
    logic re;
    forever begin
      @(negedge clk);
      re = (read_en === 1'b1);
      if (re) begin
        rd_pulses++;
        if (fifo_empty) rd_err++;
      end
      @(posedge clk);
      #1;
      if (re && rd_ptr != wr_ptr) begin
        fifo_data  = mem[rd_ptr];
        rd_ptr     = rd_ptr + 1;
        fifo_valid = 1'b1;
      end else begin
        fifo_valid = 1'b0;
      end
    end
  end

  // Line decoder: one record per completed byte frame.
  logic [7:0] rx_q[$];
  longint     rx_t[$];
  int         start_cnt = 0;
  int         mon_err = 0;

  initial begin : rx_mon
    logic [FB-1:0] fr;
    logic          v;
    bit            abort;
    longint        t0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx === 1'b0) begin
        t0 = cyc;
        start_cnt++;
        if (busy !== 1'b1) mon_err++;
        abort = 0;
        fr = '0;
        v = 1'b0;
        for (int b = 0; b < FB && !abort; b++) begin
          for (int c = 0; c < CPB && !abort; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (rst !== 1'b0) abort = 1;
            else if (c == 0) begin
              v = tx;
              fr[b] = tx;
            end else if (tx !== v) mon_err++;
          end
        end
        if (!abort) begin
          if (fr[0] !== 1'b0 || fr[FB-1] !== 1'b1) mon_err++;
`ifdef UART_PARITY_EN
          if (fr[9] !== ^fr[8:1]) mon_err++;
`endif
          rx_q.push_back(fr[8:1]);
          rx_t.push_back(t0);
        end
      end
    end
  end

  // Packet completion monitor.
  int len_q[$];
  int done_err = 0;
  initial begin : done_mon
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && pkt_done === 1'b1) begin
        len_q.push_back(int'(pkt_len));
        if (busy !== 1'b0) done_err++;
      end
    end
  end

  // Expected stream for the current phase.
  logic [7:0] exp_b[$];
  int         exp_role[$];
  int         exp_len[$];
  logic [7:0] pay_q[$];
  logic [7:0] burst_q[$];
  int rx_base, len_base, rd_base, s0;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input logic [7:0] b, input int role);
    exp_b.push_back(b);
    exp_role.push_back(role);
  endtask

  // A packet on the wire: SOF, payload, XOR of payload, EOF.
  task automatic model_packet();
    logic [7:0] cs;
    cs = 8'h00;
    exp_push(8'hA5, R_SOF);
    foreach (pay_q[i]) begin
      exp_push(pay_q[i], R_PAY);
      cs = cs ^ pay_q[i];
    end
    exp_push(cs, R_CSUM);
    exp_push(8'h5A, R_EOF);
    exp_len.push_back(pay_q.size());
  endtask

  // Bytes all present up front are cut into packets of at most MAXP.
  task automatic model_burst();
    int i;
    i = 0;
    while (i < burst_q.size()) begin
      pay_q.delete();
      for (int j = 0; j < MAXP && i < burst_q.size(); j++) begin
        pay_q.push_back(burst_q[i]);
        i++;
      end
      model_packet();
    end
  endtask

  task automatic fifo_push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic begin_phase();
    exp_b.delete();
    exp_role.delete();
    exp_len.delete();
    rx_base  = rx_q.size();
    len_base = len_q.size();
    rd_base  = rd_pulses;
    s0       = start_cnt;
  endtask

  task automatic finish_phase(input string name, input int nreads);
    int target, budget, idx, gap, eg;
    target = len_base + exp_len.size();
    budget = 6000;
    while (len_q.size() < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check({name, " done_timeout"}, longint'(budget > 0), 1);
    repeat (20) @(negedge clk);
    check({name, " byte_count"}, rx_q.size() - rx_base, exp_b.size());
    for (int k = 0; k < exp_b.size(); k++) begin
      idx = rx_base + k;
      if (idx < rx_q.size()) begin
        check($sformatf("%s byte[%0d]", name, k), rx_q[idx], exp_b[k]);
        if (exp_role[k] != R_SOF && k > 0) begin
          gap = int'(rx_t[idx] - rx_t[idx-1]) - FB * CPB;
          eg = (exp_role[k] == R_PAY) ? 2 : (exp_role[k] == R_CSUM) ? 1 : 0;
          check($sformatf("%s gap[%0d]", name, k), gap, eg);
        end
      end
    end
    check({name, " pkt_count"}, len_q.size() - len_base, exp_len.size());
    for (int p = 0; p < exp_len.size(); p++) begin
      if (len_base + p < len_q.size())
        check($sformatf("%s pkt_len[%0d]", name, p), len_q[len_base+p], exp_len[p]);
    end
    check({name, " read_pulses"}, rd_pulses - rd_base, nreads);
  endtask

  initial begin : stimulus
    int n, budget;
    logic [7:0] b1, b2, b3;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset tx", tx, 1);
    check("reset busy", busy, 0);
    check("reset read_en", read_en, 0);
    check("reset pkt_done", pkt_done, 0);
    check("reset pkt_len", pkt_len, 0);
    rst = 1'b0;

    // Idle with an empty FIFO.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle outputs", {tx, busy, read_en, pkt_done}, 4'b1000);
    end

    // Three bytes preloaded.
    begin_phase();
    burst_q = '{8'h11, 8'h22, 8'h44};
    model_burst();
    foreach (burst_q[i]) fifo_push(burst_q[i]);
    finish_phase("three_bytes", 3);

    // Six bytes split at the payload limit.
    begin_phase();
    burst_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    model_burst();
    foreach (burst_q[i]) fifo_push(burst_q[i]);
    finish_phase("split_six", 6);

    // FIFO runs dry after one byte; a byte arriving during CSUM opens a new packet.
    begin_phase();
    fifo_push(8'h3C);
    budget = 2000;
    while (start_cnt < s0 + 3 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("dry wait_csum", longint'(budget > 0), 1);
    fifo_push(8'h81);
    pay_q = '{8'h3C};
    model_packet();
    pay_q = '{8'h81};
    model_packet();
    finish_phase("dry_fifo", 2);

    // Random bursts.
    for (int r = 0; r < 6; r++) begin
      begin_phase();
      n = $urandom_range(1, 11);
      burst_q.delete();
      for (int i = 0; i < n; i++) burst_q.push_back(8'($urandom_range(0, 255)));
      model_burst();
      foreach (burst_q[i]) fifo_push(burst_q[i]);
      finish_phase($sformatf("random%0d", r), n);
    end

    // Single payload 0x07 (parity 1 in the parity build).
    begin_phase();
    burst_q = '{8'h07};
    model_burst();
    fifo_push(8'h07);
    finish_phase("payload_07", 1);

    // Reset during the second data bit of the second payload byte.
    begin_phase();
    b1 = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255)) & 8'hFD;
    b3 = 8'($urandom_range(0, 255));
    fifo_push(b1);
    fifo_push(b2);
    fifo_push(b3);
    budget = 2000;
    while (start_cnt < s0 + 3 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("abort wait_byte2", longint'(budget > 0), 1);
    repeat (9) @(negedge clk);
    #2;
    check("abort tx_before", tx, 0);
    rst = 1'b1;
    #1;
    check("abort tx", tx, 1);
    check("abort busy", busy, 0);
    check("abort read_en", read_en, 0);
    check("abort pkt_done", pkt_done, 0);
    check("abort pkt_len", pkt_len, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_push(8'hA5, R_SOF);
    exp_push(b1, R_PAY);
    pay_q = '{b3};
    model_packet();
    finish_phase("abort", 3);

    check("line frame errors", mon_err, 0);
    check("read while empty", rd_err, 0);
    check("busy at pkt_done", done_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
